l2_req_arbiter: RTL

Front-end arbiter and sequencer for the shared L2 cache controller. Accepts three independent requesters: I-cache miss port, D-cache miss port and a cache-maintenance port. Grants one at a time and drives the L2 controller's `i_op`/`d_op`/`op` request lines with a stable address and data. Waits for the matching ready, then returns data and a one-cycle acknowledge, with a watchdog on stalled transactions.

---
 rtl/l2_req_arbiter_if.sv | 53 +++++
 rtl/l2_req_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter_if.sv
// Bus bundle between the three L2 requesters, the arbiter and the L2 controller.
interface l2_req_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // I-cache miss port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    // D-cache miss port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    // Maintenance port
    logic              c_req;
    logic [6:0]        c_op;
    logic [ADDR_W-1:0] c_addr;
    logic              c_ack;
    // L2 controller side
    logic              l2_i_op;
    logic [1:0]        l2_d_op;
    logic [6:0]        l2_op;
    logic [ADDR_W-1:0] l2_addr;
    logic [DATA_W-1:0] l2_wdata;
    logic              l2_init;
    logic              l2_ready_i;
    logic              l2_ready_d;
    logic              l2_ready_op;
    logic [DATA_W-1:0] l2_rdata;
    // Status
    logic              busy;
    logic              err;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_req, c_op, c_addr,
               l2_init, l2_ready_i, l2_ready_d, l2_ready_op, l2_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, c_ack,
               l2_i_op, l2_d_op, l2_op, l2_addr, l2_wdata, busy, err
    );

    // Requester / L2 environment view
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_req, c_op, c_addr,
               l2_init, l2_ready_i, l2_ready_d, l2_ready_op, l2_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, c_ack,
               l2_i_op, l2_d_op, l2_op, l2_addr, l2_wdata, busy, err
    );
endinterface

// File: rtl/l2_req_arbiter.sv
// Front-end arbiter for the shared L2: grants one of I/D/maintenance, holds the L2
// request lines until the matching ready (or watchdog expiry), then acks for one cycle.
module l2_req_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst_n,
    l2_req_arbiter_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [1:0] GntI = 2'd0;
    localparam logic [1:0] GntD = 2'd1;
    localparam logic [1:0] GntC = 2'd2;

    // Count value in the last WAIT cycle before the watchdog fires
    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              pri_d_q, pri_d_d;
    logic [7:0]        wd_q, wd_d;
    logic              l2_i_op_q, l2_i_op_d;
    logic [1:0]        l2_d_op_q, l2_d_op_d;
    logic [6:0]        l2_op_q, l2_op_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [DATA_W-1:0] l2_wdata_q, l2_wdata_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d, c_ack_q, c_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ready_match;

    // Only the ready strobe belonging to the current grant completes it
    always_comb begin
        ready_match = ((gnt_q == GntI) && bus.l2_ready_i) ||
                      ((gnt_q == GntD) && bus.l2_ready_d) ||
                      ((gnt_q == GntC) && bus.l2_ready_op);
    end

    // Arbitration, L2 sequencing and watchdog next-state
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        pri_d_d    = pri_d_q;
        wd_d       = wd_q;
        l2_i_op_d  = l2_i_op_q;
        l2_d_op_d  = l2_d_op_q;
        l2_op_d    = l2_op_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        c_ack_d    = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.l2_init) begin
                    if (bus.c_req) begin
                        gnt_d = GntC;
                        if (bus.c_op[2:1] == 2'b00) begin
                            // Unsupported op: ack without touching the L2
                            c_ack_d = 1'b1;
                            state_d = StResp;
                        end else begin
                            l2_op_d    = bus.c_op;
                            l2_addr_d  = bus.c_addr;
                            l2_wdata_d = '0;
                            wd_d       = '0;
                            state_d    = StWait;
                        end
                    end else if (bus.d_req && (pri_d_q || !bus.i_req)) begin
                        gnt_d      = GntD;
                        pri_d_d    = 1'b0;
                        l2_d_op_d  = {bus.d_we, ~bus.d_we};
                        l2_addr_d  = bus.d_addr;
                        l2_wdata_d = bus.d_wdata;
                        wd_d       = '0;
                        state_d    = StWait;
                    end else if (bus.i_req) begin
                        gnt_d      = GntI;
                        pri_d_d    = 1'b1;
                        l2_i_op_d  = 1'b1;
                        l2_addr_d  = bus.i_addr;
                        l2_wdata_d = '0;
                        wd_d       = '0;
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (ready_match || (wd_q == WdLast)) begin
                    // A ready arriving in the final watchdog cycle still wins
                    l2_i_op_d = 1'b0;
                    l2_d_op_d = 2'b00;
                    l2_op_d   = '0;
                    i_ack_d   = (gnt_q == GntI);
                    d_ack_d   = (gnt_q == GntD);
                    c_ack_d   = (gnt_q == GntC);
                    if (!ready_match) err_d = 1'b1;
                    if (gnt_q == GntI) i_rdata_d = ready_match ? bus.l2_rdata : '0;
                    if (gnt_q == GntD) d_rdata_d = ready_match ? bus.l2_rdata : '0;
                    state_d = StResp;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= GntI;
            pri_d_q    <= 1'b1;
            wd_q       <= '0;
            l2_i_op_q  <= 1'b0;
            l2_d_op_q  <= 2'b00;
            l2_op_q    <= '0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            c_ack_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            pri_d_q    <= pri_d_d;
            wd_q       <= wd_d;
            l2_i_op_q  <= l2_i_op_d;
            l2_d_op_q  <= l2_d_op_d;
            l2_op_q    <= l2_op_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            c_ack_q    <= c_ack_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.l2_i_op  = l2_i_op_q;
    assign bus.l2_d_op  = l2_d_op_q;
    assign bus.l2_op    = l2_op_q;
    assign bus.l2_addr  = l2_addr_q;
    assign bus.l2_wdata = l2_wdata_q;
    assign bus.i_ack    = i_ack_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.c_ack    = c_ack_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
endmodule
